// File: rtl/tensor_core_types_pkg.sv
// -----------------------------------------------------------------------------
// tensor_core_types_pkg
// Shared widths and types for the scalar side of the tensor-core pipeline.
//   WORD_W   : scalar data word width (ALU result, load data, write data)
//   REG_AW   : scalar register index width (32 registers)
//   wb_out_t : register-file write port driven by the writeback stage
// -----------------------------------------------------------------------------
package tensor_core_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              s_rw_en;
    logic [REG_AW-1:0] s_rw;
    logic [WORD_W-1:0] s_wdata;
  } wb_out_t;

endpackage : tensor_core_types_pkg

// File: rtl/writeback_if.sv
// -----------------------------------------------------------------------------
// writeback_if
// Bundle between execute/memory stages, the writeback stage and the register
// file.
//   alu_ready / alu_out / reg_sel_alu      : ALU result and its destination
//   load_ready / dmemload / reg_sel_load   : load data and its destination
//   alu_stall                              : ALU result not taken this cycle
//   wb_out                                 : registered register-file write
// Modports: wb (writeback stage side), tb (environment side).
// -----------------------------------------------------------------------------
interface writeback_if;
  import tensor_core_types_pkg::*;

  logic              alu_ready;
  logic [WORD_W-1:0] alu_out;
  logic [REG_AW-1:0] reg_sel_alu;
  logic              load_ready;
  logic [WORD_W-1:0] dmemload;
  logic [REG_AW-1:0] reg_sel_load;
  logic              alu_stall;
  wb_out_t           wb_out;

  modport wb (
    input  alu_ready, alu_out, reg_sel_alu,
    input  load_ready, dmemload, reg_sel_load,
    output alu_stall, wb_out
  );

  modport tb (
    output alu_ready, alu_out, reg_sel_alu,
    output load_ready, dmemload, reg_sel_load,
    input  alu_stall, wb_out
  );

endinterface : writeback_if

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// Scalar writeback stage. Each cycle picks the load result (priority) or the
// ALU result and registers a single register-file write.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset of the output register
//   wbif : writeback_if.wb
//          inputs  alu_ready, alu_out, reg_sel_alu,
//                  load_ready, dmemload, reg_sel_load
//          outputs alu_stall (combinational), wb_out (registered)
// Widths come from tensor_core_types_pkg (WORD_W = 32, REG_AW = 5).
// -----------------------------------------------------------------------------
module writeback
  import tensor_core_types_pkg::*;
(
  input logic     CLK,
  input logic     RST,
  writeback_if.wb wbif
);

  wb_out_t wb_out_r;
  wb_out_t wb_next_s;
  logic    alu_stall_s;

  // Next write selection: load beats ALU; idle cycles keep index/data.
  always_comb begin
    wb_next_s         = wb_out_r;
    wb_next_s.s_rw_en = 1'b0;
    if (wbif.load_ready) begin
      wb_next_s.s_rw_en = 1'b1;
      wb_next_s.s_rw    = wbif.reg_sel_load;
      wb_next_s.s_wdata = wbif.dmemload;
    end else if (wbif.alu_ready) begin
      wb_next_s.s_rw_en = 1'b1;
      wb_next_s.s_rw    = wbif.reg_sel_alu;
      wb_next_s.s_wdata = wbif.alu_out;
    end else begin
      wb_next_s.s_rw_en = 1'b0;
    end
    // r0 is hard-wired zero: never write it, arbitration is unaffected.
    if (wb_next_s.s_rw == {REG_AW{1'b0}}) begin
      wb_next_s.s_rw_en = 1'b0;
    end else begin
      wb_next_s.s_rw_en = wb_next_s.s_rw_en;
    end
  end

  // ALU loses when a load is present; nothing is buffered, upstream holds.
  always_comb begin
    alu_stall_s = wbif.alu_ready & wbif.load_ready & ~RST;
  end

  // Output register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_out_r <= '{s_rw_en: 1'b0, s_rw: {REG_AW{1'b0}}, s_wdata: {WORD_W{1'b0}}};
    end else begin
      wb_out_r <= wb_next_s;
    end
  end

  assign wbif.alu_stall = alu_stall_s;
  assign wbif.wb_out    = wb_out_r;

endmodule : writeback

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
// Directed self-checking bench for the writeback stage. Inputs change 1 ns
// after a rising edge; alu_stall is checked before the next edge and wb_out
// 1 ns after it.
// -----------------------------------------------------------------------------
module tb_writeback;
  import tensor_core_types_pkg::*;

  logic CLK;
  logic RST;
  int   pass_cnt;
  int   total_cnt;

  writeback_if wbif ();

  writeback dut (
    .CLK  (CLK),
    .RST  (RST),
    .wbif (wbif.wb)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ar, input logic [WORD_W-1:0] ad, input logic [REG_AW-1:0] ars,
                       input logic lr, input logic [WORD_W-1:0] ld, input logic [REG_AW-1:0] lrs);
    wbif.alu_ready    = ar;
    wbif.alu_out      = ad;
    wbif.reg_sel_alu  = ars;
    wbif.load_ready   = lr;
    wbif.dmemload     = ld;
    wbif.reg_sel_load = lrs;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 32'h1111_1111, 5'd9, 1'b1, 32'h2222_2222, 5'd10);
    total_cnt++;
    if (wbif.alu_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", wbif.alu_stall);
    else pass_cnt++;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0);
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b0, s_rw: 5'd0, s_wdata: 32'h0})
      $display("FAIL reset_wb_out: got %h expected %h", wbif.wb_out, {1'b0, 5'd0, 32'h0});
    else pass_cnt++;
    total_cnt++;
    if (wbif.alu_stall !== 1'b0) $display("FAIL reset_stall_idle: got %b expected 0", wbif.alu_stall);
    else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_alu_only();
    drive(1'b1, 32'hADD0_0ADD, 5'd1, 1'b0, 32'h0, 5'd0);
    total_cnt++;
    if (wbif.alu_stall !== 1'b0) $display("FAIL alu_only_stall: got %b expected 0", wbif.alu_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd1, s_wdata: 32'hADD0_0ADD})
      $display("FAIL alu_only_wb_out: got %h expected %h", wbif.wb_out, {1'b1, 5'd1, 32'hADD0_0ADD});
    else pass_cnt++;
  endtask

  task automatic test_load_only();
    drive(1'b0, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 5'd2);
    total_cnt++;
    if (wbif.alu_stall !== 1'b0) $display("FAIL load_only_stall: got %b expected 0", wbif.alu_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd2, s_wdata: 32'hDEAD_BEEF})
      $display("FAIL load_only_wb_out: got %h expected %h", wbif.wb_out, {1'b1, 5'd2, 32'hDEAD_BEEF});
    else pass_cnt++;
  endtask

  task automatic test_both_ready();
    drive(1'b1, 32'h1234_5678, 5'd3, 1'b1, 32'hFEED_FADE, 5'd4);
    total_cnt++;
    if (wbif.alu_stall !== 1'b1) $display("FAIL both_stall: got %b expected 1", wbif.alu_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd4, s_wdata: 32'hFEED_FADE})
      $display("FAIL both_load_wins: got %h expected %h", wbif.wb_out, {1'b1, 5'd4, 32'hFEED_FADE});
    else pass_cnt++;
    // Upstream keeps the ALU result; load goes away.
    drive(1'b1, 32'h1234_5678, 5'd3, 1'b0, 32'hFEED_FADE, 5'd4);
    total_cnt++;
    if (wbif.alu_stall !== 1'b0) $display("FAIL both_retry_stall: got %b expected 0", wbif.alu_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd3, s_wdata: 32'h1234_5678})
      $display("FAIL both_retry_alu: got %h expected %h", wbif.wb_out, {1'b1, 5'd3, 32'h1234_5678});
    else pass_cnt++;
  endtask

  task automatic test_idle_r0();
    drive(1'b0, 32'hAAAA_AAAA, 5'd6, 1'b0, 32'hBBBB_BBBB, 5'd7);
    step();
    total_cnt++;
    if (wbif.wb_out.s_rw_en !== 1'b0) $display("FAIL idle_en: got %b expected 0", wbif.wb_out.s_rw_en);
    else pass_cnt++;
    total_cnt++;
    if (wbif.wb_out.s_rw !== 5'd3 || wbif.wb_out.s_wdata !== 32'h1234_5678)
      $display("FAIL idle_hold: got %h/%h expected 03/12345678", wbif.wb_out.s_rw, wbif.wb_out.s_wdata);
    else pass_cnt++;
    // ALU write to r0 is dropped.
    drive(1'b1, 32'hCAFE_0000, 5'd0, 1'b0, 32'h0, 5'd0);
    step();
    total_cnt++;
    if (wbif.wb_out.s_rw_en !== 1'b0) $display("FAIL r0_alu_en: got %b expected 0", wbif.wb_out.s_rw_en);
    else pass_cnt++;
    // Load to r0 still wins arbitration and stalls the ALU.
    drive(1'b1, 32'h5555_5555, 5'd5, 1'b1, 32'h6666_6666, 5'd0);
    total_cnt++;
    if (wbif.alu_stall !== 1'b1) $display("FAIL r0_load_stall: got %b expected 1", wbif.alu_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wbif.wb_out.s_rw_en !== 1'b0) $display("FAIL r0_load_en: got %b expected 0", wbif.wb_out.s_rw_en);
    else pass_cnt++;
    // Released: the held ALU result to r5 goes through.
    drive(1'b1, 32'h5555_5555, 5'd5, 1'b0, 32'h0, 5'd0);
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd5, s_wdata: 32'h5555_5555})
      $display("FAIL r0_release: got %h expected %h", wbif.wb_out, {1'b1, 5'd5, 32'h5555_5555});
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h0BAD_F00D, 5'd7, 1'b0, 32'h0, 5'd0);
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd7, s_wdata: 32'h0BAD_F00D})
      $display("FAIL mid_pre: got %h expected %h", wbif.wb_out, {1'b1, 5'd7, 32'h0BAD_F00D});
    else pass_cnt++;
    RST = 1'b1;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b0, s_rw: 5'd0, s_wdata: 32'h0})
      $display("FAIL mid_reset: got %h expected %h", wbif.wb_out, {1'b0, 5'd0, 32'h0});
    else pass_cnt++;
    RST = 1'b0;
    step();
    total_cnt++;
    if (wbif.wb_out !== '{s_rw_en: 1'b1, s_rw: 5'd7, s_wdata: 32'h0BAD_F00D})
      $display("FAIL mid_resume: got %h expected %h", wbif.wb_out, {1'b1, 5'd7, 32'h0BAD_F00D});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RST       = 1'b1;
    wbif.alu_ready    = 1'b0;
    wbif.alu_out      = 32'h0;
    wbif.reg_sel_alu  = 5'd0;
    wbif.load_ready   = 1'b0;
    wbif.dmemload     = 32'h0;
    wbif.reg_sel_load = 5'd0;
    step();
    test_reset();
    test_alu_only();
    test_load_only();
    test_both_ready();
    test_idle_r0();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_writeback

// File: doc/writeback.md
Name: writeback

Overview:
- Scalar writeback stage of the tensor-core pipeline.
- Arbitrates between an ALU result and a data-memory load result each cycle.
- Produces one registered register-file write (enable, register index, data) per cycle.
- Sits between the execute/memory stages and the scalar register file; connected through the writeback_if interface bundle.

Parameters:
- DATA_W, 32, width of ALU result, load data and write data
- REG_AW, 5, width of register index (32 scalar registers)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- wbif  interface  -  writeback_if, DUT-side modport; members listed below
- wbif.alu_ready  input  1  ALU result valid this cycle
- wbif.alu_out  input  DATA_W  ALU result
- wbif.reg_sel_alu  input  REG_AW  destination register of ALU result
- wbif.load_ready  input  1  load data valid this cycle
- wbif.dmemload  input  DATA_W  load data from data memory
- wbif.reg_sel_load  input  REG_AW  destination register of load
- wbif.alu_stall  output  1  ALU result not accepted this cycle; upstream must hold it
- wbif.wb_out  output  struct  {s_rw_en 1b, s_rw REG_AW, s_wdata DATA_W}; register-file write port

Behaviour:
- Reset: RST high at a rising edge clears the wb_out register next cycle: s_rw_en=0, s_rw=0, s_wdata=0. While RST is high, alu_stall=0.
- Reset mid-operation: any pending selection is discarded; no write is issued in the cycle after reset.
- Latency: one cycle. Inputs sampled at rising edge N appear on wb_out after edge N and hold until edge N+1.
- Selection, evaluated combinationally and registered at the edge:
  - load_ready=1 -> s_rw_en=1, s_rw=reg_sel_load, s_wdata=dmemload. Load has priority.
  - else alu_ready=1 -> s_rw_en=1, s_rw=reg_sel_alu, s_wdata=alu_out.
  - else -> s_rw_en=0; s_rw and s_wdata hold their previous values (don't-care to the consumer).
- Simultaneous load_ready and alu_ready: load is written. alu_stall=1 combinationally in that cycle, and the ALU result is not written or buffered internally. The upstream stage must keep alu_ready and its data asserted until alu_stall=0.
- alu_stall = alu_ready & load_ready & ~RST; purely combinational, no registered state.
- Register 0 writes are suppressed: if the selected destination is 0, s_rw_en=0. The load still wins arbitration, so alu_stall still asserts.
- Widths are passed through unmodified; no sign or zero extension.
- No other state, no FSM. The only storage is the wb_out register.

Decomposition:
- Shared package (e.g. tensor_core_types_pkg):
  - constants WORD_W=32 and REG_AW=5
  - typedef wb_out_t {logic s_rw_en; logic [REG_AW-1:0] s_rw; logic [WORD_W-1:0] s_wdata}
- writeback_if lives in its own .vh/.sv. It declares the signals above plus modports wb (DUT side) and tb.
- No sub-module; a single always_comb selector plus an always_ff output register is natural. An optional helper, wb_arbiter, is acceptable if the priority logic is factored out.

Test Plan:
- Reset: RST=1 for 1 cycle, all inputs 0 -> wb_out.s_rw_en=0, s_rw=0, s_wdata=0, alu_stall=0.
- ALU only: alu_ready=1, alu_out=0xADD00ADD, reg_sel_alu=1 -> after next edge s_rw_en=1, s_rw=1, s_wdata=0xADD00ADD; alu_stall=0.
- Load only: load_ready=1, dmemload=0xDEADBEEF, reg_sel_load=2 -> after next edge s_rw_en=1, s_rw=2, s_wdata=0xDEADBEEF.
- Both ready:
  - Stimulus: alu_out=0x12345678, reg_sel_alu=3, dmemload=0xFEEDFADE, reg_sel_load=4.
  - Response: alu_stall=1 in the same cycle; after next edge s_rw_en=1, s_rw=4, s_wdata=0xFEEDFADE. Holding alu_ready the following cycle with load_ready=0 writes s_rw=3, s_wdata=0x12345678.
- Idle and r0: both ready=0 -> s_rw_en=0 after next edge. alu_ready=1 with reg_sel_alu=0 -> s_rw_en=0.
- Reset mid-stream: alu_ready=1 held while RST pulses high for one edge -> s_rw_en=0 after that edge; normal writes resume on the following edge.
